pid_channel_scheduler: RTL and testbench

- Time-shares one incremental PID datapath (a single 16x16 signed multiplier and a 34-bit accumulator) across NCH control channels.
- Arbitrates round-robin between per-channel sample requests.
- Holds per-channel setpoint and history (e1, e2, u_prev), sequences the three gain multiplies, and writes back the saturated output.
- Sits between the sensor front-ends and the actuator outputs. Gains and setpoints come from a simple config write port.

---
 rtl/pid_channel_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_pid_channel_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pid_channel_scheduler.sv
// Shares one incremental PID datapath (16x16 multiplier, 34-bit accumulator)
// across NCH channels with round-robin request arbitration.
//
// state | meaning
// IDLE  | waiting for a request; config writes accepted here
// ERR   | ack the granted channel, form e = sp - meas, load u_prev
// M0    | acc += K0 * e
// M1    | acc += K1 * e1
// M2    | acc += K2 * e2, register saturated result
// WB    | out_valid pulse, shift channel history
module pid_channel_scheduler #(
    parameter int                 NCH        = 4,
    parameter int                 CHW        = 2,
    parameter logic signed [15:0] SP_DEFAULT = 16'sd200,
    parameter logic signed [15:0] K0_DEFAULT = 16'sd3,
    parameter logic signed [15:0] K1_DEFAULT = -16'sd2,
    parameter logic signed [15:0] K2_DEFAULT = 16'sd2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req,
    input  logic [16*NCH-1:0]       meas,
    output logic [NCH-1:0]          ack,
    output logic                    out_valid,
    output logic [CHW-1:0]          out_ch,
    output logic signed [15:0]      out_data,
    output logic                    busy,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_addr,
    input  logic [15:0]             cfg_wdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_M0   = 3'd2;
    localparam logic [2:0] S_M1   = 3'd3;
    localparam logic [2:0] S_M2   = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;

    logic [2:0]          state;
    logic [CHW-1:0]      ch;
    logic [CHW-1:0]      rr_ptr;
    logic [CHW-1:0]      grant_ch;
    logic [CHW-1:0]      rr_next;
    logic                grant_any;
    logic [CHW:0]        first_off;
    logic [CHW:0]        grant_sum;
    logic [CHW:0]        rr_sum;
    logic [2*NCH-1:0]    req_dbl;
    logic [NCH-1:0]      req_rot;

    logic signed [15:0]  meas_sel;
    logic signed [15:0]  meas_lat;
    logic signed [15:0]  e_cur;
    logic signed [15:0]  k0;
    logic signed [15:0]  k1;
    logic signed [15:0]  k2;
    logic signed [15:0]  mul_a;
    logic signed [15:0]  mul_b;
    logic signed [31:0]  prod;
    logic signed [33:0]  acc;
    logic signed [33:0]  acc_sum;
    logic                cfg_ok;

    logic signed [15:0]  sp     [NCH];
    logic signed [15:0]  e1     [NCH];
    logic signed [15:0]  e2     [NCH];
    logic signed [15:0]  u_prev [NCH];

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767) return 16'sh7fff;
        if (v < -34'sd32768) return 16'sh8000;
        return v[15:0];
    endfunction

    assign busy   = (state != S_IDLE);
    assign cfg_ok = cfg_we && (state == S_IDLE);

    // Rotate requests so bit 0 is the channel at rr_ptr; the lowest set bit wins.
    always_comb begin
        req_dbl   = {req, req};
        req_rot   = NCH'(req_dbl >> rr_ptr);
        grant_any = |req;
        first_off = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            if (req_rot[off]) first_off = (CHW+1)'(off);
        end
        grant_sum = {1'b0, rr_ptr} + first_off;
        if (grant_sum >= (CHW+1)'(NCH)) grant_sum = grant_sum - (CHW+1)'(NCH);
        grant_ch = grant_sum[CHW-1:0];
        rr_sum   = {1'b0, grant_ch} + (CHW+1)'(1);
        if (rr_sum == (CHW+1)'(NCH)) rr_next = '0;
        else                         rr_next = rr_sum[CHW-1:0];
    end

    always_comb begin
        meas_sel = meas[15:0];
        for (int i = 0; i < NCH; i++) begin
            if (grant_ch == CHW'(i)) meas_sel = meas[16*i +: 16];
        end
    end

    always_comb begin
        mul_a = k0;
        mul_b = e_cur;
        case (state)
            S_M1: begin
                mul_a = k1;
                mul_b = e1[ch];
            end
            S_M2: begin
                mul_a = k2;
                mul_b = e2[ch];
            end
            default: begin
                mul_a = k0;
                mul_b = e_cur;
            end
        endcase
        prod    = mul_a * mul_b;
        acc_sum = acc + {{2{prod[31]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ch        <= '0;
            rr_ptr    <= '0;
            meas_lat  <= '0;
            e_cur     <= '0;
            acc       <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        ch       <= grant_ch;
                        meas_lat <= meas_sel;
                        rr_ptr   <= rr_next;
                        ack      <= NCH'(1) << grant_ch;
                        state    <= S_ERR;
                    end
                end
                S_ERR: begin
                    e_cur <= sp[ch] - meas_lat;
                    acc   <= {{18{u_prev[ch][15]}}, u_prev[ch]};
                    state <= S_M0;
                end
                S_M0: begin
                    acc   <= acc_sum;
                    state <= S_M1;
                end
                S_M1: begin
                    acc   <= acc_sum;
                    state <= S_M2;
                end
                // Result is registered here so it is already stable during WB.
                S_M2: begin
                    acc       <= acc_sum;
                    out_data  <= sat16(acc_sum);
                    out_ch    <= ch;
                    out_valid <= 1'b1;
                    state     <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Channel history and configuration; writes only land while idle, so
    // they never collide with the WB history shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            k0 <= K0_DEFAULT;
            k1 <= K1_DEFAULT;
            k2 <= K2_DEFAULT;
            for (int i = 0; i < NCH; i++) begin
                sp[i]     <= SP_DEFAULT;
                e1[i]     <= '0;
                e2[i]     <= '0;
                u_prev[i] <= '0;
            end
        end else begin
            if (state == S_WB) begin
                e2[ch]     <= e1[ch];
                e1[ch]     <= e_cur;
                u_prev[ch] <= out_data;
            end
            if (cfg_ok) begin
                case (cfg_addr)
                    4'h0: k0 <= cfg_wdata;
                    4'h1: k1 <= cfg_wdata;
                    4'h2: k2 <= cfg_wdata;
                    4'h3: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (cfg_wdata[CHW-1:0] == CHW'(i)) begin
                                e1[i]     <= '0;
                                e2[i]     <= '0;
                                u_prev[i] <= '0;
                            end
                        end
                    end
                    default: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (cfg_addr == 4'(8 + i)) sp[i] <= cfg_wdata;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed bench for pid_channel_scheduler: arithmetic, round-robin order,
// saturation, config timing, reset abandonment and channel clear.
module tb_pid_channel_scheduler;

    localparam int NCH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NCH-1:0]       req = '0;
    logic [16*NCH-1:0]    meas = '0;
    logic [NCH-1:0]       ack;
    logic                 out_valid;
    logic [1:0]           out_ch;
    logic signed [15:0]   out_data;
    logic                 busy;
    logic                 cfg_we = 1'b0;
    logic [3:0]           cfg_addr = '0;
    logic [15:0]          cfg_wdata = '0;

    int checks = 0;
    int errors = 0;
    int last_ack_at;
    int last_val_at;
    int got_ch;
    int got_data;
    int valid_seen;

    pid_channel_scheduler #(.NCH(NCH), .CHW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .meas      (meas),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .busy      (busy),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = '0;
        cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Waits for the next result, dropping each req bit once it is acked;
    // returns one cycle after the pulse so the FSM is back in IDLE.
    task automatic wait_result();
        got_ch      = -1;
        got_data    = 0;
        last_ack_at = -1;
        last_val_at = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ack != '0) begin
                if (last_ack_at < 0) last_ack_at = n;
                req = req & ~ack;
            end
            if (out_valid) begin
                got_ch      = int'(out_ch);
                got_data    = int'(out_data);
                last_val_at = n;
                break;
            end
        end
        if (last_val_at < 0) check("out_valid_timeout", last_val_at, 5);
        @(negedge clk);
    endtask

    task automatic run_one(input int ch, input int exp, input string tag);
        req[ch] = 1'b1;
        wait_result();
        check({tag, "_ch"}, got_ch, ch);
        check({tag, "_data"}, got_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        check("rst_ack", int'(ack), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);

        // Repeated ch0 samples build up history: 600, 800, 1400.
        req[0] = 1'b1;
        wait_result();
        check("t1_ack_latency", last_ack_at, 1);
        check("t1_valid_latency", last_val_at, 5);
        check("t1_s1_ch", got_ch, 0);
        check("t1_s1_data", got_data, 600);
        run_one(0, 800, "t1_s2");
        run_one(0, 1400, "t1_s3");
        check("t1_hold_data", int'(out_data), 1400);

        // Round-robin ordering.
        do_reset();
        req = 4'b0110;
        wait_result();
        check("t2_first_ch", got_ch, 1);
        check("t2_first_data", got_data, 600);
        wait_result();
        check("t2_second_ch", got_ch, 2);
        check("t2_second_data", got_data, 600);
        req = 4'b0011;
        wait_result();
        check("t2_third_ch", got_ch, 0);
        check("t2_third_data", got_data, 600);
        wait_result();
        check("t2_fourth_ch", got_ch, 1);
        check("t2_fourth_data", got_data, 800);

        // Saturation at both rails.
        do_reset();
        cfg_write(4'h0, 16'h7fff);
        cfg_write(4'hb, 16'h7fff);
        run_one(3, 32767, "t3_pos_sat");
        cfg_write(4'hb, 16'h8000);
        run_one(3, -32768, "t3_neg_sat");

        // Nonzero measurement gives a negative error: e=200-250=-50, u=-150.
        do_reset();
        meas[63:48] = 16'd250;
        run_one(3, -150, "t3_neg_err");
        meas = '0;

        // Config write while busy is dropped.
        do_reset();
        req[1] = 1'b1;
        @(negedge clk);
        check("t4_ack_ch1", int'(ack), 2);
        req[1] = 1'b0;
        check("t4_busy", int'(busy), 1);
        cfg_write(4'h8, 16'd100);
        wait_result();
        check("t4_busy_sample_data", got_data, 600);
        run_one(0, 600, "t4_dropped_sp");

        // Config write in the grant cycle lands before ERR.
        do_reset();
        req[0]    = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'h8;
        cfg_wdata = 16'd100;
        @(negedge clk);
        cfg_we = 1'b0;
        check("t4_grant_ack", int'(ack), 1);
        req[0] = 1'b0;
        wait_result();
        check("t4_grant_write_data", got_data, 300);

        // Reset during M1 abandons the sample.
        do_reset();
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        valid_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 1) reset = 1'b0;
            if (out_valid) valid_seen++;
        end
        check("t5_no_valid", valid_seen, 0);
        check("t5_busy_after", int'(busy), 0);
        run_one(0, 600, "t5_after_reset");

        // Clearing one channel leaves the others alone.
        do_reset();
        run_one(1, 600, "t6_ch1_s1");
        run_one(2, 600, "t6_ch2_s1");
        run_one(2, 800, "t6_ch2_s2");
        cfg_write(4'h3, 16'd2);
        cfg_write(4'h4, 16'h7fff);
        cfg_write(4'hc, 16'h7fff);
        run_one(2, 600, "t6_ch2_cleared");
        run_one(1, 800, "t6_ch1_kept");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
